mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Arbitrates NUM_REQ core-side memory requesters onto one single-ported, pipelined
//  memory. Typical requesters: instruction fetch (port 0) and LSU data (port 1).
//  Provides a valid/ready request handshake with fixed- or round-robin priority.
//  Each accepted request returns exactly one response, tagged to its requester,
//  MEM_LATENCY cycles later. This lets the core run on a unified memory with wait states.
// PARAMETERS
//  NUM_REQ      2   number of requester ports (1..8)
//  ADDR_W       32  address width, byte addressed
//  DATA_W       32  data width; byte-enable width BE_W = DATA_W/8
//  MEM_LATENCY  1   cycles from mem_en to valid mem_rd_data (1..4)
//  RR_MODE      0   0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  clk           in   1               clock, rising edge
//  rst           in   1               asynchronous reset, active-high
//  req_valid     in   NUM_REQ         request present, one bit per port
//  req_ready     out  NUM_REQ         request accepted this cycle (one-hot or zero)
//  req_addr      in   NUM_REQ*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W]
//  req_we        in   NUM_REQ*BE_W    packed byte write enables; all zero = read
//  req_wdata     in   NUM_REQ*DATA_W  packed write data
//  rsp_valid     out  NUM_REQ         response pulse, at most one bit set
//  rsp_rd_data   out  DATA_W          read data for the port flagged in rsp_valid
//  mem_ready     in   1               memory can take a command this cycle
//  mem_en        out  1               memory command strobe
//  mem_addr      out  ADDR_W          memory address
//  mem_we        out  BE_W            memory byte write enables
//  mem_wr_data   out  DATA_W          memory write data
//  mem_rd_data   in   DATA_W          read data, valid MEM_LATENCY cycles after mem_en
//  busy          out  1               any response in flight
// BEHAVIOUR
//  - Reset: rr_ptr=0 and tag pipe cleared; req_ready, rsp_valid, mem_en, mem_we and busy
//    read 0; rsp_rd_data=0. Any in-flight response is dropped and never delivered.
//  - Grant: combinational. Candidates = req_valid & {NUM_REQ{mem_ready}}.
//    RR_MODE=0: lowest-index candidate wins.
//    RR_MODE=1: first candidate searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
//  - req_ready = one-hot grant. Handshake completes when req_valid[i] & req_ready[i].
//    A requester holds valid, addr, we and wdata stable until accepted.
//  - On acceptance, the same cycle drives mem_en=1 and the muxed addr, we and wdata of
//    the winner. With no acceptance, mem_en=0 and mem_we=0.
//  - rr_ptr updates only on acceptance: rr_ptr <= (granted+1) mod NUM_REQ.
//  - Tag pipe: MEM_LATENCY-deep shift register of {valid, port_id, is_write}; shifts
//    every cycle regardless of mem_ready. Memory is fully pipelined: one command per cycle.
//  - Response: when the pipe output is valid, rsp_valid[port_id]=1 for exactly one cycle.
//    Reads: rsp_rd_data = mem_rd_data. Writes: rsp_rd_data=0 (the pulse acts as write ack).
//    Responses complete in acceptance order. Requesters cannot backpressure responses.
//  - Throughput: 1 request/cycle. Back-to-back same-port requests are legal.
//  - busy = OR of tag-pipe valid bits.
//  - mem_ready=0: no grant, pointer frozen, in-flight responses still retire on time.
//  - NUM_REQ=1: the grant is req_valid & mem_ready; rr_ptr is constant 0.
//  - Out-of-range req_addr is passed through unchecked; no alignment checking.
// TESTING
//  1 Reset mid-flight: accept a read at cycle 0 (MEM_LATENCY=2), assert rst at cycle 1
//    -> no rsp_valid ever; busy=0 after reset.
//  2 Fixed priority: RR_MODE=0, both ports valid for 3 cycles
//    -> req_ready=01,01,01; port 1 starves; rsp_valid=01 for 3 cycles after latency.
//  3 Round-robin: RR_MODE=1, NUM_REQ=3, all valid for 6 cycles
//    -> grants 0,1,2,0,1,2; each rsp_valid bit pulses twice.
//  4 Read/write mix: port1 writes 0xDEADBEEF (we=4'hF) to 0x100, then port0 reads 0x100
//    -> write ack with rsp_rd_data=0; read returns 0xDEADBEEF exactly MEM_LATENCY cycles
//    after its accept.
//  5 mem_ready low: deassert for 2 cycles while a read is in flight
//    -> req_ready=0 both cycles; in-flight response still arrives on time; rr_ptr unchanged.
//  6 Latency sweep MEM_LATENCY=1..4: back-to-back reads to 0x0,0x4,0x8
//    -> three consecutive rsp_valid pulses, data in order.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-side signals of mem_port_arbiter bundled as one interface.
// The master modport is the environment (requesters + memory); the slave modport is the arbiter.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*BE_W-1:0]   req_we;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rd_data;
  logic                      mem_ready;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [BE_W-1:0]           mem_we;
  logic [DATA_W-1:0]         mem_wr_data;
  logic [DATA_W-1:0]         mem_rd_data;
  logic                      busy;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, mem_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rd_data, mem_en, mem_addr, mem_we, mem_wr_data, busy
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, mem_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_rd_data, mem_en, mem_addr, mem_we, mem_wr_data, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto one pipelined single-ported memory (fixed or round-robin),
// returning one tagged response per accepted request MEM_LATENCY cycles later, in order.
module mem_port_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int RR_MODE     = 0
) (
  input  logic          clk,
  input  logic          rst,
  mem_port_arbiter_if.slave bus
);
  localparam int          BE_W = DATA_W / 8;
  localparam int          ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR   = NUM_REQ;
  localparam int unsigned LAT  = MEM_LATENCY;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic               grant_hit;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;

  logic               pipe_v  [LAT];
  logic [ID_W-1:0]    pipe_id [LAT];
  logic               pipe_wr [LAT];

  // Fixed priority is the round-robin search with its start pinned at port 0.
  always_comb begin
    int unsigned idx;
    cand      = bus.req_valid & {NUM_REQ{bus.mem_ready & ~rst}};
    grant     = '0;
    grant_id  = '0;
    grant_hit = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (RR_MODE != 0) ? ((32'(rr_ptr) + k) % NR) : k;
      if (!grant_hit && cand[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        grant_hit  = 1'b1;
      end
    end
  end

  assign bus.req_ready = grant;

  always_comb begin
    bus.mem_en      = grant_hit;
    bus.mem_addr    = '0;
    bus.mem_we      = '0;
    bus.mem_wr_data = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (grant[i]) begin
        bus.mem_addr    = bus.req_addr[i*ADDR_W +: ADDR_W];
        bus.mem_we      = bus.req_we[i*BE_W +: BE_W];
        bus.mem_wr_data = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        pipe_v[k]  <= 1'b0;
        pipe_id[k] <= '0;
        pipe_wr[k] <= 1'b0;
      end
    end else begin
      if (grant_hit) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      pipe_v[0]  <= grant_hit;
      pipe_id[0] <= grant_id;
      pipe_wr[0] <= |bus.mem_we;
      for (int unsigned k = 1; k < LAT; k++) begin
        pipe_v[k]  <= pipe_v[k-1];
        pipe_id[k] <= pipe_id[k-1];
        pipe_wr[k] <= pipe_wr[k-1];
      end
    end
  end

  // Writes retire as a bare ack with zero data.
  always_comb begin
    bus.rsp_valid   = '0;
    bus.rsp_rd_data = '0;
    if (pipe_v[LAT-1]) begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (pipe_id[LAT-1] == ID_W'(i)) begin
          bus.rsp_valid[i] = 1'b1;
        end
      end
      if (!pipe_wr[LAT-1]) begin
        bus.rsp_rd_data = bus.mem_rd_data;
      end
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    for (int unsigned k = 0; k < LAT; k++) begin
      bus.busy = bus.busy | pipe_v[k];
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiter configurations driven with random traffic; a behavioural
// model predicts grants and responses, and a monitor retires them against the DUT outputs.
module tb_mem_port_arbiter;
  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input int cfg_i, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0h, expected %0h at %0t", cfg_i, name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int w);
    return 32'h1357_9BDF ^ (32'(w) * 32'h0101_0101);
  endfunction

  // cfg0: 2 ports, latency 1, fixed priority.  cfg1: 3 ports, latency 3, round-robin.
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NR  = (g == 0) ? 2 : 3;
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int RR  = (g == 0) ? 0 : 1;

    logic rst  = 1'b1;
    int   cyc  = 0;
    bit   done = 1'b0;
    exp_t q[$];

    mem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
      .NUM_REQ(NR), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .RR_MODE(RR)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pipelined memory: read data appears LAT cycles after the command strobe.
    logic [31:0] mem     [16];
    logic [31:0] rd_pipe [LAT];
    bit          mem_init = 1'b0;

    always @(posedge clk) begin
      logic [31:0] nw;
      int          w;
      w = int'(bus.mem_addr[5:2]);
      if (!mem_init) begin
        for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
        mem_init <= 1'b1;
      end else if (bus.mem_en) begin
        nw = mem[w];
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b]) nw[8*b +: 8] = bus.mem_wr_data[8*b +: 8];
        mem[w] <= nw;
      end
      rd_pipe[0] <= (bus.mem_en && mem_init) ? mem[w] : $urandom();
      for (int k = LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign bus.mem_rd_data = rd_pipe[LAT-1];

    // Stimulus + reference model
    initial begin
      bit          pend [NR];
      logic [31:0] a_r  [NR];
      logic [3:0]  we_r [NR];
      logic [31:0] wd_r [NR];
      logic [31:0] ref_mem [16];
      logic [NR-1:0] exp_rdy;
      int rr, gnt, idx, w;

      for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
      for (int i = 0; i < NR; i++) begin
        pend[i] = 1'b0; a_r[i] = '0; we_r[i] = '0; wd_r[i] = '0;
      end
      rr = 0;
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_we    = '0;
      bus.req_wdata = '0;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);

      for (int c = 0; c < 420; c++) begin
        @(posedge clk);
        #1;
        if (c == 0 || c == 3 || c == 252) rst = 1'b0;
        if (c == 1 || c == 250) begin
          rst = 1'b1;
          q.delete();
          rr = 0;
        end
        if (c == 0) begin
          pend[0] = 1'b1; a_r[0] = 32'h100; we_r[0] = 4'h0; wd_r[0] = $urandom();
        end else if (c == 1) begin
          pend[1] = 1'b1; a_r[1] = 32'h100; we_r[1] = 4'hF; wd_r[1] = 32'hDEADBEEF;
        end else if (c >= 3 && c < 400) begin
          for (int i = 0; i < NR; i++) begin
            if (!pend[i] && (c < 13 || $urandom_range(0, 1) == 1)) begin
              pend[i] = 1'b1;
              a_r[i]  = ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
              we_r[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
              wd_r[i] = $urandom();
            end
          end
        end
        bus.mem_ready = (c < 13 || c >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
        for (int i = 0; i < NR; i++) begin
          bus.req_valid[i]         = pend[i];
          bus.req_addr[i*32 +: 32] = a_r[i];
          bus.req_we[i*4 +: 4]     = we_r[i];
          bus.req_wdata[i*32 +: 32] = wd_r[i];
        end

        @(negedge clk);
        gnt = -1;
        if (!rst && bus.mem_ready) begin
          for (int k = 0; k < NR; k++) begin
            idx = ((RR != 0 ? rr : 0) + k) % NR;
            if (gnt < 0 && pend[idx]) gnt = idx;
          end
        end
        exp_rdy = '0;
        if (gnt >= 0) exp_rdy[gnt] = 1'b1;
        chk(g, "req_ready", bus.req_ready, exp_rdy);
        chk(g, "mem_en", bus.mem_en, gnt >= 0);
        if (gnt >= 0) begin
          chk(g, "mem_addr", bus.mem_addr, a_r[gnt]);
          chk(g, "mem_we", bus.mem_we, we_r[gnt]);
          chk(g, "mem_wr_data", bus.mem_wr_data, wd_r[gnt]);
          w = int'(a_r[gnt][5:2]);
          if (we_r[gnt] == 4'h0) begin
            q.push_back('{gnt, ref_mem[w], cyc + LAT});
          end else begin
            for (int b = 0; b < 4; b++)
              if (we_r[gnt][b]) ref_mem[w][8*b +: 8] = wd_r[gnt][8*b +: 8];
            q.push_back('{gnt, 32'h0, cyc + LAT});
          end
          rr = (gnt + 1) % NR;
          pend[gnt] = 1'b0;
        end else begin
          chk(g, "mem_we_idle", bus.mem_we, 4'h0);
        end
      end
      chk(g, "drain_queue", q.size(), 0);
      done = 1'b1;
    end

    // Response monitor
    initial begin
      exp_t          e;
      logic [NR-1:0] ev;
      bit            busy_exp;
      forever begin
        @(negedge clk);
        busy_exp = 1'b0;
        foreach (q[i]) if (q[i].due < cyc + LAT) busy_exp = 1'b1;
        chk(g, "busy", bus.busy, busy_exp);
        if (rst) chk(g, "rsp_rd_data_rst", bus.rsp_rd_data, 32'h0);
        if (bus.rsp_valid != '0) begin
          if (q.size() == 0) begin
            chk(g, "rsp_unexpected", bus.rsp_valid, '0);
          end else begin
            e  = q.pop_front();
            ev = '0;
            ev[e.port] = 1'b1;
            chk(g, "rsp_valid", bus.rsp_valid, ev);
            chk(g, "rsp_rd_data", bus.rsp_rd_data, e.data);
            chk(g, "rsp_cycle", cyc, e.due);
          end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
          e  = q.pop_front();
          ev = '0;
          ev[e.port] = 1'b1;
          chk(g, "rsp_missing", bus.rsp_valid, ev);
        end
      end
    end
  end

  initial begin
    wait (cfg[0].done && cfg[1].done);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: test did not complete, done flags %0b%0b expected 11",
             cfg[1].done, cfg[0].done);
    $fatal(1, "watchdog expired");
  end
endmodule
